// File: rtl/transform_8_to_4_2_seq.sv
// Forward isomorphism GF(2^8) -> GF((2^4)^2), evaluating ROWS_PER_CYCLE matrix rows per clock.
// Optional macro FWD_XFORM_SELFCHECK_EN adds a sticky chk_err driven by an inverse-map check in DONE.
module transform_8_to_4_2_seq #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
`ifdef FWD_XFORM_SELFCHECK_EN
    ,
    output logic       chk_err
`endif
);

    if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2 && ROWS_PER_CYCLE != 4 && ROWS_PER_CYCLE != 8)
    begin : g_bad_rows
        $error("ROWS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The BUSY cycle whose base row is LAST_BASE writes row 7.
    localparam logic [2:0] LAST_BASE = 3'(8 - ROWS_PER_CYCLE);
    localparam logic [2:0] ROW_STEP  = 3'(ROWS_PER_CYCLE & 7);

    function automatic logic [7:0] fwd_row(input logic [2:0] idx);
        logic [7:0] row;
        case (idx)
            3'd0:    row = 8'b1010_0000;
            3'd1:    row = 8'b1010_1100;
            3'd2:    row = 8'b1101_0010;
            3'd3:    row = 8'b0111_0000;
            3'd4:    row = 8'b1100_0110;
            3'd5:    row = 8'b0101_0010;
            3'd6:    row = 8'b0000_1010;
            default: row = 8'b1101_1101;
        endcase
        return row;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] opnd_q, opnd_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] res_q, res_d;
    logic [2:0] row_idx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        res_d   = res_q;
        row_idx = row_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opnd_d  = in_data;
                    acc_d   = '0;
                    row_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
                    row_idx = row_q + 3'(k);
                    acc_d[3'd7 - row_idx] = ^(fwd_row(row_idx) & opnd_q);
                end
                row_d = row_q + ROW_STEP;
                if (row_q == LAST_BASE) begin
                    res_d   = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    // Gated by rst so in_ready is low for the whole reset, not just after the first edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;

`ifdef FWD_XFORM_SELFCHECK_EN
    function automatic logic [7:0] inv_map(input logic [7:0] v);
        logic [7:0] rows [8];
        logic [7:0] r;
        rows = '{8'h24, 8'hEE, 8'hA4, 8'h5A, 8'hB2, 8'h72, 8'hB0, 8'h51};
        r = '0;
        for (int i = 0; i < 8; i++) r[7 - i] = ^(rows[i] & v);
        return r;
    endfunction

    logic chk_err_q, chk_err_d;

    always_comb begin
        chk_err_d = chk_err_q;
        if (state_q == DONE && inv_map(res_q) != opnd_q) chk_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chk_err_q <= 1'b0;
        else     chk_err_q <= chk_err_d;
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_transform_8_to_4_2_seq.sv
// Randomized bench for transform_8_to_4_2_seq: four instances (R=1,2,4,8) against a matrix reference model.
module tb_transform_8_to_4_2_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [4];
    logic       in_ready  [4];
    logic [7:0] in_data   [4];
    logic       out_valid [4];
    logic       out_ready [4];
    logic [7:0] out_data  [4];
`ifdef FWD_XFORM_SELFCHECK_EN
    logic       chk_err   [4];
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        transform_8_to_4_2_seq #(.ROWS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
`ifdef FWD_XFORM_SELFCHECK_EN
            ,
            .chk_err   (chk_err[g])
`endif
        );
    end

    localparam logic [7:0] FWD_T [8] = '{8'hA0, 8'hAC, 8'hD2, 8'h70, 8'hC6, 8'h52, 8'h0A, 8'hDD};
    localparam logic [7:0] INV_T [8] = '{8'h24, 8'hEE, 8'hA4, 8'h5A, 8'hB2, 8'h72, 8'hB0, 8'h51};

    // Matrix-vector product over GF(2); row i produces output bit 7-i.
    function automatic logic [7:0] mat_mul(input bit inverse, input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[7 - i] = ^((inverse ? INV_T[i] : FWD_T[i]) & v);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance d. stall<0 holds out_ready high throughout; otherwise
    // out_ready stays low for 'stall' DONE cycles while in_valid/in_data are toggled.
    task automatic xfer(input int d, input logic [7:0] b, input int stall);
        int         lat;
        int         waits;
        logic [7:0] exp;
        exp   = mat_mul(1'b0, b);
        waits = 0;
        while (!in_ready[d] && waits < 20) begin
            tick();
            waits++;
        end
        check("in_ready_before_accept", 32'(in_ready[d]), 32'd1);
        in_valid[d]  = 1'b1;
        in_data[d]   = b;
        out_ready[d] = (stall < 0);
        tick();
        in_data[d] = 8'($urandom);
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            in_valid[d] = 1'($urandom);
            in_data[d]  = 8'($urandom);
            tick();
            lat++;
        end
        in_valid[d] = 1'b0;
        check("latency", 32'(lat), 32'(8 >> d));
        check("out_data", 32'(out_data[d]), 32'(exp));
        check("round_trip", 32'(mat_mul(1'b1, out_data[d])), 32'(b));
        for (int s = 0; s < stall; s++) begin
            in_valid[d] = 1'($urandom);
            in_data[d]  = 8'($urandom);
            tick();
            check("stall_out_valid", 32'(out_valid[d]), 32'd1);
            check("stall_out_data", 32'(out_data[d]), 32'(exp));
            check("stall_in_ready", 32'(in_ready[d]), 32'd0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        tick();
        check("out_valid_drop", 32'(out_valid[d]), 32'd0);
        check("in_ready_idle", 32'(in_ready[d]), 32'd1);
        check("out_data_hold", 32'(out_data[d]), 32'(exp));
        out_ready[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 8'h00;
            out_ready[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 4; d++) begin
            check("reset_in_ready", 32'(in_ready[d]), 32'd0);
            check("reset_out_valid", 32'(out_valid[d]), 32'd0);
            check("reset_out_data", 32'(out_data[d]), 32'd0);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) check("post_reset_in_ready", 32'(in_ready[d]), 32'd1);

        // Directed vectors, R=1, out_ready held high.
        xfer(0, 8'h00, -1);
        xfer(0, 8'h01, -1);
        xfer(0, 8'h02, -1);
        xfer(0, 8'h80, -1);
        xfer(0, 8'hFF, -1);
        check("vec_FF", 32'(out_data[0]), 32'h14);

        // Latency sweep across R.
        for (int d = 1; d < 4; d++) begin
            xfer(d, 8'h80, -1);
            check("sweep_80", 32'(out_data[d]), 32'hE9);
        end

        // Backpressure: five held DONE cycles with in_valid toggling.
        xfer(0, 8'h80, 5);
        check("bp_result", 32'(out_data[0]), 32'hE9);
        xfer(0, 8'h01, -1);

        // Round trip over every byte, every R, with random stalls.
        for (int d = 0; d < 4; d++)
            for (int b = 0; b < 256; b++)
                xfer(d, 8'(b), int'($urandom_range(0, 3)) - 1);

        // Async reset in BUSY at row 4.
        in_valid[0]  = 1'b1;
        in_data[0]   = 8'h55;
        out_ready[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("busy_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("busy_rst_in_ready", 32'(in_ready[0]), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("busy_rst_release_in_ready", 32'(in_ready[0]), 32'd1);
        xfer(0, 8'h02, -1);
        check("after_rst_02", 32'(out_data[0]), 32'h2E);

        // Async reset while holding a result in DONE.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h80;
        tick();
        in_valid[0] = 1'b0;
        repeat (8) tick();
        check("done_before_rst", 32'(out_valid[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("done_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("done_rst_out_data", 32'(out_data[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("done_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("done_rst_no_pulse", 32'(out_valid[0]), 32'd0);

`ifdef FWD_XFORM_SELFCHECK_EN
        // Corrupt the accumulator mid-operation; the inverse check must flag it.
        check("chk_err_clean", 32'(chk_err[0]), 32'd0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h80;
        tick();
        in_valid[0] = 1'b0;
        tick();
        force g_dut[0].u_dut.acc_q = 8'h00;
        repeat (7) tick();
        release g_dut[0].u_dut.acc_q;
        check("chk_in_done", 32'(out_valid[0]), 32'd1);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("chk_err_set", 32'(chk_err[0]), 32'd1);
        xfer(0, 8'h02, -1);
        check("chk_err_sticky", 32'(chk_err[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("chk_err_reset", 32'(chk_err[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
